// File: rtl/instr_encoder_if.sv
// Handshake bus of the instruction encoder: field-set input side and encoded-word output side.
// The master drives fields and consumes words; the slave is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field sets into 32-bit words, tags each with a word
// address and an illegal-field flag, and buffers them in a 2-entry output FIFO.
module instr_encoder #(
  parameter int               ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_encoder_if.slave      bus,
  output logic [15:0]         instr_count,
  output logic [7:0]          err_count,
  output logic                addr_wrap
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  entry_t            mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic              push;
  logic              pop;
  logic              is_shift;
  logic [31:0]       imm;

  assign imm      = bus.in_imm;
  assign is_shift = (bus.in_opcode == 7'b0010011) &&
                    ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  // Range checks require the bits above the encoded field to be a pure sign extension.
  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = 1'b0;
    case (bus.in_type)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: begin
        if (is_shift) begin
          enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
          enc_err  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
          enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
        end
      end
      3'd2: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
        enc_err  = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      end
      3'd4: begin
        enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err  = |imm[11:0];
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        enc_err  = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Acceptance ignores out_ready, so a full FIFO blocks input even while it is draining.
  assign bus.in_ready  = !rst && (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_instr = mem[rd_ptr].instr;
  assign bus.out_addr  = mem[rd_ptr].addr;
  assign bus.out_err   = mem[rd_ptr].err;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      addr_cnt    <= BASE_ADDR;
      instr_count <= 16'd0;
      err_count   <= 8'd0;
      addr_wrap   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: enc_word, addr: addr_cnt, err: enc_err};
        wr_ptr      <= !wr_ptr;
        addr_cnt    <= addr_cnt + 1'b1;
        instr_count <= instr_count + 16'd1;
        if (&addr_cnt) addr_wrap <= 1'b1;
        if (enc_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure, wrap, reset
// and a randomized run compared against a queue-based reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) bus();
  instr_encoder_if #(.ADDR_W(2)) bus2();

  logic [15:0] instr_count, instr_count2;
  logic [7:0]  err_count, err_count2;
  logic        addr_wrap, addr_wrap2;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .instr_count(instr_count), .err_count(err_count), .addr_wrap(addr_wrap)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .instr_count(instr_count2), .err_count(err_count2), .addr_wrap(addr_wrap2)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  addr;
    logic        err;
  } item_t;

  item_t       mq[$];
  logic [7:0]  m_addr = 8'd0;
  logic [15:0] m_icnt = 16'd0;
  logic [7:0]  m_ecnt = 8'd0;
  logic        m_wrap = 1'b0;
  int checks = 0;
  int errors = 0;

  // Reference encoder built from shifted fields and signed value ranges.
  function automatic void ref_encode(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] w, output logic e);
    int s;
    logic [31:0] base;
    s = imm;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    e = 1'b0;
    case (t)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      3'd1: begin
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (32'(f7) << 25) | ((imm & 32'd31) << 20) | base | (32'(rd) << 7);
          e = (imm > 32'd31);
        end else begin
          w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
          e = (s < -2048) || (s > 2047);
        end
      end
      3'd2: begin
        w = (((imm >> 5) & 32'd127) << 25) | (32'(rs2) << 20) | base | ((imm & 32'd31) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (32'(rs2) << 20) | base |
            (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7);
        e = ((imm & 32'd1) != 0) || (s < -4096) || (s > 4095);
      end
      3'd4: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        e = (imm % 32'd4096) != 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) | (((imm >> 11) & 32'd1) << 20) |
            (((imm >> 12) & 32'd255) << 12) | (32'(rd) << 7) | 32'(op);
        e = ((imm & 32'd1) != 0) || (s < -1048576) || (s > 1048575);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic set_word(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    bus.in_type = t; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
  endtask

  // One clock: predict the handshakes from the model, advance, settle at the falling edge.
  task automatic tick();
    bit acc, pop;
    logic [31:0] w;
    logic e;
    acc = (bus.in_valid === 1'b1) && !rst && (mq.size() < 2);
    pop = (mq.size() > 0) && (bus.out_ready === 1'b1);
    ref_encode(bus.in_type, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
               bus.in_funct3, bus.in_funct7, bus.in_imm, w, e);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_addr = 8'd0; m_icnt = 16'd0; m_ecnt = 8'd0; m_wrap = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{instr: w, addr: m_addr, err: e});
        if (m_addr == 8'hFF) m_wrap = 1'b1;
        m_addr = m_addr + 8'd1;
        m_icnt = m_icnt + 16'd1;
        if (e && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    set_word(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    checks++; if (bus.out_addr !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_addr: got %h want 0", bus.out_addr); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b want 0", bus.out_err); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_instr_count: got %0d want 0", instr_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (addr_wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_wrap: got %b want 0", addr_wrap); end
  endtask

  task automatic test_directed();
    logic [31:0] exp_w;
    logic        exp_e;
    logic [7:0]  exp_ec;
    reset_dut();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin set_word(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);  exp_w = 32'h002081B3; exp_e = 1'b0; exp_ec = 8'd0; end
        1: begin set_word(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF); exp_w = 32'hFFF00093; exp_e = 1'b0; exp_ec = 8'd0; end
        2: begin set_word(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); exp_w = 32'h80000093; exp_e = 1'b1; exp_ec = 8'd1; end
        3: begin set_word(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);   exp_w = 32'h00208463; exp_e = 1'b0; exp_ec = 8'd1; end
        default: begin set_word(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7); exp_w = 32'h00208363; exp_e = 1'b1; exp_ec = 8'd2; end
      endcase
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_out_valid: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_instr !== exp_w) begin errors++; $display("[TB] FAIL dir%0d_instr: got %h want %h", i, bus.out_instr, exp_w); end
      checks++; if (bus.out_err !== exp_e) begin errors++; $display("[TB] FAIL dir%0d_err: got %b want %b", i, bus.out_err, exp_e); end
      checks++; if (bus.out_addr !== 8'(i)) begin errors++; $display("[TB] FAIL dir%0d_addr: got %0d want %0d", i, bus.out_addr, i); end
      checks++; if (err_count !== exp_ec) begin errors++; $display("[TB] FAIL dir%0d_err_count: got %0d want %0d", i, err_count, exp_ec); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic e;
    int n;
    reset_dut();
    for (int k = 0; k < 3; k++)
      ref_encode(3'd0, 7'b0110011, 5'(k + 1), 5'd4, 5'd5, 3'd0, 7'd0, 32'd0, w[k], e);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_word(3'd0, 7'b0110011, 5'(k + 1), 5'd4, 5'd5, 3'd0, 7'd0, 32'd0);
      tick();
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (instr_count !== 16'd2) begin errors++; $display("[TB] FAIL bp_full_count: got %0d want 2", instr_count); end
    tick();
    checks++; if (bus.out_instr !== w[0]) begin errors++; $display("[TB] FAIL bp_hold_instr: got %h want %h", bus.out_instr, w[0]); end
    checks++; if (bus.out_addr !== 8'd0) begin errors++; $display("[TB] FAIL bp_hold_addr: got %0d want 0", bus.out_addr); end
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12 && n < 3; c++) begin
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_addr !== 8'(n)) begin errors++; $display("[TB] FAIL bp_order_addr%0d: got %0d want %0d", n, bus.out_addr, n); end
        checks++; if (bus.out_instr !== w[n]) begin errors++; $display("[TB] FAIL bp_order_instr%0d: got %h want %h", n, bus.out_instr, w[n]); end
        n++;
      end
      bus.in_valid = (m_icnt < 16'd3);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL bp_drain_words: got %0d want 3", n); end
    checks++; if (instr_count !== 16'd3) begin errors++; $display("[TB] FAIL bp_instr_count: got %0d want 3", instr_count); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_word(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (k == 255) begin
        checks++; if (addr_wrap !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wrap_early: got %b want 0", addr_wrap); end
      end
      if (k == 256) begin
        checks++; if (addr_wrap !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wrap_set: got %b want 1", addr_wrap); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL b2b_err_sat: got %0d want 255", err_count); end
    checks++; if (instr_count !== 16'd260) begin errors++; $display("[TB] FAIL b2b_instr_count: got %0d want 260", instr_count); end
    checks++; if (bus.out_addr !== 8'd3) begin errors++; $display("[TB] FAIL b2b_last_addr: got %0d want 3", bus.out_addr); end
    checks++; if (bus.out_instr !== 32'h13 || bus.out_err !== 1'b1) begin errors++; $display("[TB] FAIL b2b_nop: got %h/%b want 00000013/1", bus.out_instr, bus.out_err); end
    checks++; if (addr_wrap !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wrap_sticky: got %b want 1", addr_wrap); end
    tick();
  endtask

  task automatic test_wrap();
    reset_dut();
    bus2.in_type = 3'd0; bus2.in_opcode = 7'b0110011; bus2.in_rd = 5'd7; bus2.in_rs1 = 5'd8;
    bus2.in_rs2 = 5'd9; bus2.in_funct3 = 3'd0; bus2.in_funct7 = 7'd0; bus2.in_imm = 32'd0;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (bus2.out_addr !== 2'((k - 1) % 4)) begin errors++; $display("[TB] FAIL wrap_addr%0d: got %0d want %0d", k, bus2.out_addr, (k - 1) % 4); end
      checks++; if (addr_wrap2 !== (k >= 4)) begin errors++; $display("[TB] FAIL wrap_flag%0d: got %b want %b", k, addr_wrap2, (k >= 4)); end
    end
    bus2.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_word(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick(); tick();
    checks++; if (instr_count !== 16'd2) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d want 2", instr_count); end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_in_ready: got %b want 0", bus.in_ready); end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (instr_count !== 16'd0 || err_count !== 8'd0) begin errors++; $display("[TB] FAIL mid_counters: got %0d/%0d want 0/0", instr_count, err_count); end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_addr !== 8'd0 || bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_next_addr: got %0d/%b want 0/1", bus.out_addr, bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h123452B7) begin errors++; $display("[TB] FAIL mid_next_instr: got %h want 123452b7", bus.out_instr); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] imm;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = 32'($urandom_range(0, 63));
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      set_word(3'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0) ? 7'b0010011 : 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      checks++; if (bus.in_ready !== (mq.size() < 2)) begin errors++; $display("[TB] FAIL rnd_in_ready c%0d: got %b want %b", c, bus.in_ready, (mq.size() < 2)); end
      checks++; if (bus.out_valid !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rnd_out_valid c%0d: got %b want %b", c, bus.out_valid, (mq.size() != 0)); end
      if (mq.size() != 0) begin
        checks++;
        if (bus.out_instr !== mq[0].instr || bus.out_addr !== mq[0].addr || bus.out_err !== mq[0].err) begin
          errors++;
          $display("[TB] FAIL rnd_word c%0d: got %h@%0d err%b want %h@%0d err%b", c, bus.out_instr, bus.out_addr,
                   bus.out_err, mq[0].instr, mq[0].addr, mq[0].err);
        end
      end
      checks++;
      if (instr_count !== m_icnt || err_count !== m_ecnt || addr_wrap !== m_wrap) begin
        errors++;
        $display("[TB] FAIL rnd_counters c%0d: got %0d/%0d/%b want %0d/%0d/%b", c, instr_count, err_count, addr_wrap,
                 m_icnt, m_ecnt, m_wrap);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_word(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.in_type = 3'd0; bus2.in_opcode = 7'd0;
    bus2.in_rd = 5'd0; bus2.in_rs1 = 5'd0; bus2.in_rs2 = 5'd0; bus2.in_funct3 = 3'd0;
    bus2.in_funct7 = 7'd0; bus2.in_imm = 32'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: width of the emitted word address.
REQ-002 Parameter BASE_ADDR, default 0: first address after reset; width ADDR_W.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port in_valid, input, 1: field set on in_* is valid.
REQ-006 Port in_ready, output, 1: encoder accepts the field set this cycle.
REQ-007 Port in_type, input, 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 invalid.
REQ-008 Ports in_opcode (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3) and in_funct7 (7) are inputs: RV32I instruction fields.
REQ-009 Port in_imm, input, 32: signed byte-offset or immediate value.
REQ-010 Port out_valid, output, 1: out_* holds an encoded word.
REQ-011 Port out_ready, input, 1: consumer takes the word this cycle.
REQ-012 Port out_instr, output, 32: encoded instruction word.
REQ-013 Port out_addr, output, ADDR_W: word address assigned to out_instr.
REQ-014 Port out_err, output, 1: word was generated from an illegal field set.
REQ-015 Ports instr_count (16) and err_count (8) are outputs: accepted-word and error-word counters.
REQ-016 Port addr_wrap, output, 1: sticky flag, address counter has wrapped.

Function
REQ-017 Accept (in_valid&&in_ready): the word is encoded combinationally and pushed into a 2-entry output FIFO on the same edge; out_valid rises the next cycle, so latency is 1 cycle when the FIFO is empty.
REQ-018 in_ready = !rst && (fifo_count<2), with no dependence on out_ready; pop when out_valid&&out_ready; push+pop in one cycle leaves the count unchanged.
REQ-019 FIFO order is preserved; out_instr, out_addr and out_err hold stable while out_valid&&!out_ready.
REQ-020 R: {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-021 I: {imm[11:0],rs1,funct3,rd,opcode}; err if imm[31:11] is not all-equal.
REQ-022 I-shift (opcode 0010011, funct3 001/101): {funct7,imm[4:0],rs1,funct3,rd,opcode}; err if imm[31:5]!=0.
REQ-023 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; range check as I.
REQ-024 B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; err if imm[0]=1 or imm[31:12] is not all-equal.
REQ-025 U: {imm[31:12],rd,opcode}; err if imm[11:0]!=0.
REQ-026 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; err if imm[0]=1 or imm[31:20] is not all-equal.
REQ-027 in_type 6/7: out_instr=0x00000013 (NOP), err=1.
REQ-028 An error word is still emitted and addressed, with the field truncation applied, and flagged via out_err.
REQ-029 Address counter: starts at BASE_ADDR and increments by 1 per accepted word; the stored out_addr is the pre-increment value.
REQ-030 Address counter wraps from 2^ADDR_W-1 to 0; addr_wrap sets on that increment and stays set until reset.
REQ-031 instr_count increments per accepted word and wraps at 16 bits.
REQ-032 err_count increments per accepted error word and saturates at 255.

Reset
REQ-033 When rst is high at an edge: FIFO emptied, out_valid=0, out_instr=0, out_addr=0, out_err=0, address counter=BASE_ADDR, instr_count=0, err_count=0, addr_wrap=0.
REQ-034 Reset mid-transfer discards all FIFO contents; no word is accepted while rst=1.
REQ-035 in_ready is 1 on the first cycle after rst falls.

Verification
REQ-036 R type0 op=0110011 rd=3 rs1=1 rs2=2 f3=0 f7=0, out_ready=1 -> next cycle out_instr=0x002081B3, out_addr=0, out_err=0.
REQ-037 I type1 op=0010011 rd=1 rs1=0 f3=0 imm=0xFFFFFFFF -> 0xFFF00093, err=0; repeat with imm=2048 -> out_err=1, err_count=1.
REQ-038 B type3 op=1100011 rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463; repeat with imm=7 -> out_err=1.
REQ-039 out_ready=0, offer 3 words -> in_ready=0 after 2 accepts; release out_ready -> 3 words in order at addresses 0,1,2, instr_count=3.
REQ-040 ADDR_W=2, push 5 words -> addresses 0,1,2,3,0; addr_wrap=1 from the 4th push on.
REQ-041 FIFO holding 2 words, rst high for 1 cycle -> out_valid=0, counters 0, next accepted word at BASE_ADDR.
